// File: rtl/irq_ctrl.sv
// Interrupt controller: samples device IRQ lines into a W1C pending register, masks them and
// drives CP0 HWInt with lowest-index priority plus one level of service tracking.
// Optional macro IRQ_CTRL_EDGE_EN adds the TRIG register and per-source edge detection.
module irq_ctrl #(
    parameter int N_SRC = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_SRC-1:0] IRQ_IN,
    input  logic [2:0]       innerADDR,
    input  logic             WE,
    input  logic [31:0]      WD,
    output logic [31:0]      RD,
    input  logic             INT_ACK,
    output logic [N_SRC-1:0] HWInt,
    output logic [2:0]       VEC
);

    typedef enum logic {ST_IDLE, ST_SERV} state_t;

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_active, w_active_nxt;
    logic [N_SRC-1:0] r_s, r_pend, r_mask;
    logic [N_SRC-1:0] w_set, w_trig_rd, w_sw, w_clr, w_gate, w_elig;
    logic             w_wr_pend, w_wr_mask, w_wr_swset, w_wr_eoi;
    logic             w_unused;

    assign w_wr_pend  = WE && (innerADDR == 3'd0);
    assign w_wr_mask  = WE && (innerADDR == 3'd1);
    assign w_wr_swset = WE && (innerADDR == 3'd5);
    assign w_wr_eoi   = WE && (innerADDR == 3'd6);
    assign w_sw       = w_wr_swset ? WD[N_SRC-1:0] : '0;
    assign w_clr      = w_wr_pend  ? WD[N_SRC-1:0] : '0;
    assign w_unused   = ^WD[31:N_SRC];

`ifdef IRQ_CTRL_EDGE_EN
    logic [N_SRC-1:0] r_p, r_trig;
    logic             w_wr_trig;

    assign w_wr_trig = WE && (innerADDR == 3'd2);
    assign w_set     = (r_s & ~r_trig) | (r_s & ~r_p & r_trig);
    assign w_trig_rd = r_trig;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_p    <= '0;
            r_trig <= '0;
        end else begin
            r_p <= r_s;
            if (w_wr_trig)
                r_trig <= WD[N_SRC-1:0];
        end
    end
`else
    assign w_set     = r_s;
    assign w_trig_rd = '0;
`endif

    // Any set source wins over a W1C clear hitting the same bit in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s    <= '0;
            r_pend <= '0;
            r_mask <= '0;
        end else begin
            r_s    <= IRQ_IN;
            r_pend <= (r_pend & ~w_clr) | w_set | w_sw;
            if (w_wr_mask)
                r_mask <= WD[N_SRC-1:0];
        end
    end

    always_comb begin
        w_gate = '1;
        if (r_state == ST_SERV) begin
            for (int i = 0; i < N_SRC; i++)
                w_gate[i] = (i < int'(r_active));
        end
    end

    assign w_elig = r_pend & r_mask & w_gate;
    assign HWInt  = w_elig;

    always_comb begin
        VEC = 3'd7;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_elig[i])
                VEC = 3'(i);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_active <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= w_active_nxt;
        end
    end

    // EOI takes precedence over a simultaneous acknowledge; ACTIVE survives EOI for readback.
    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active;
        case (r_state)
            ST_IDLE: begin
                if (!w_wr_eoi && INT_ACK && (VEC != 3'd7)) begin
                    w_state_nxt  = ST_SERV;
                    w_active_nxt = VEC;
                end
            end
            ST_SERV: begin
                if (w_wr_eoi)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        RD = '0;
        case (innerADDR)
            3'd0:    RD = 32'(r_pend);
            3'd1:    RD = 32'(r_mask);
            3'd2:    RD = 32'(w_trig_rd);
            3'd3:    RD = 32'(r_s);
            3'd4:    RD = {24'b0, (r_state == ST_SERV), r_active, 1'b0, VEC};
            default: RD = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus randomized traffic, all checked every cycle
// against a bit-level behavioural model of the register window and service rules.
module tb_irq_ctrl;

    localparam int N = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [N-1:0] irq_in;
    logic [2:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        int_ack;
    logic [N-1:0] hwint;
    logic [2:0]  vec;

    int n_cmp = 0;
    int n_err = 0;

    bit [N-1:0] m_s, m_p, m_pend, m_mask, m_trig;
    bit         m_serv;
    bit [2:0]   m_active;

    irq_ctrl #(.N_SRC(N)) dut (
        .CLK(clk), .RST(rst), .IRQ_IN(irq_in), .innerADDR(addr), .WE(we), .WD(wd),
        .RD(rd), .INT_ACK(int_ack), .HWInt(hwint), .VEC(vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic bit eligible(input int i);
        return m_pend[i] && m_mask[i] && (!m_serv || i < int'(m_active));
    endfunction

    function automatic bit [N-1:0] m_hw();
        bit [N-1:0] e = '0;
        for (int i = 0; i < N; i++) e[i] = eligible(i);
        return e;
    endfunction

    function automatic bit [2:0] m_vec();
        for (int i = 0; i < N; i++)
            if (eligible(i)) return 3'(i);
        return 3'd7;
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] a);
        case (a)
            3'd0: return 32'(m_pend);
            3'd1: return 32'(m_mask);
            3'd2: return 32'(m_trig);
            3'd3: return 32'(m_s);
            3'd4: return {24'b0, m_serv, m_active, 1'b0, m_vec()};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        bit [N-1:0] np;
        bit [2:0]   v;
        bit         lvl_set;
        if (rst) begin
            m_s = '0; m_p = '0; m_pend = '0; m_mask = '0; m_trig = '0;
            m_serv = 1'b0; m_active = 3'd0;
            return;
        end
        v = m_vec();
        for (int i = 0; i < N; i++) begin
            lvl_set = m_trig[i] ? (m_s[i] && !m_p[i]) : m_s[i];
            if (lvl_set || (we && addr == 3'd5 && wd[i])) np[i] = 1'b1;
            else if (we && addr == 3'd0 && wd[i])         np[i] = 1'b0;
            else                                          np[i] = m_pend[i];
        end
        if (we && addr == 3'd1) m_mask = wd[N-1:0];
`ifdef IRQ_CTRL_EDGE_EN
        if (we && addr == 3'd2) m_trig = wd[N-1:0];
`endif
        if (we && addr == 3'd6) m_serv = 1'b0;
        else if (!m_serv && int_ack && v != 3'd7) begin
            m_serv   = 1'b1;
            m_active = v;
        end
        m_pend = np;
        m_p    = m_s;
        m_s    = irq_in;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("hwint_model", 32'(hwint), 32'(m_hw()));
        chk("vec_model", 32'(vec), 32'(m_vec()));
        chk("rd_model", rd, m_rd(addr));
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        addr = a; wd = d; we = 1'b1;
        tick();
        we = 1'b0; wd = '0;
    endtask

    task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string tag);
        addr = a; we = 1'b0;
        #1;
        chk(tag, rd, exp);
    endtask

    initial begin
        rst = 1'b1; irq_in = '0; addr = '0; we = 1'b0; wd = '0; int_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;

        for (int a = 0; a < 8; a++)
            rd_chk(3'(a), (a == 4) ? 32'h7 : 32'h0, "reset_rd");
        chk("reset_hwint", 32'(hwint), 32'h0);
        chk("reset_vec", 32'(vec), 32'h7);

        wr(3'd1, 32'h3F);
        irq_in = 6'h02;
        tick();
        rd_chk(3'd0, 32'h0, "lat_pend_k");
        chk("lat_hw_k", 32'(hwint), 32'h0);
        tick();
        rd_chk(3'd0, 32'h2, "lat_pend_k1");
        chk("lat_hw_k1", 32'(hwint), 32'h2);
        chk("lat_vec_k1", 32'(vec), 32'h1);
        wr(3'd0, 32'h02);
        rd_chk(3'd0, 32'h2, "w1c_level_high");
        irq_in = '0;
        tick();
        wr(3'd0, 32'h02);
        rd_chk(3'd0, 32'h0, "w1c_level_low");

        irq_in = 6'h0A;
        tick(); tick();
        chk("svc_hw_pre", 32'(hwint), 32'h0A);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        rd_chk(3'd4, 32'h97, "svc_stat");
        chk("svc_hw_gated", 32'(hwint), 32'h0);
        irq_in = 6'h0B;
        tick(); tick();
        chk("svc_hw_src0", 32'(hwint), 32'h01);
        chk("svc_vec_src0", 32'(vec), 32'h0);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        rd_chk(3'd4, 32'h90, "svc_nested_ack");
        wr(3'd6, 32'h0);
        chk("eoi_hw", 32'(hwint), 32'h0B);
        rd_chk(3'd4, 32'h10, "eoi_stat");
        irq_in = '0;
        tick(); tick();
        wr(3'd0, 32'h3F);
        rd_chk(3'd0, 32'h0, "svc_clear");

        wr(3'd5, 32'h04);
        addr = 3'd6; we = 1'b1; int_ack = 1'b1;
        tick();
        we = 1'b0; int_ack = 1'b0;
        rd_chk(3'd4, 32'h12, "eoi_ack_idle");
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        rd_chk(3'd4, 32'hA7, "ack_src2");
        addr = 3'd6; we = 1'b1; int_ack = 1'b1;
        tick();
        we = 1'b0; int_ack = 1'b0;
        rd_chk(3'd4, 32'h22, "eoi_ack_serv");
        wr(3'd0, 32'h04);

`ifdef IRQ_CTRL_EDGE_EN
        wr(3'd2, 32'h01);
        rd_chk(3'd2, 32'h1, "trig_rd");
        irq_in = 6'h01; tick(); irq_in = '0;
        tick(); tick(); tick();
        rd_chk(3'd0, 32'h1, "edge_held");
        wr(3'd0, 32'h01);
        rd_chk(3'd0, 32'h0, "edge_w1c");
        irq_in = 6'h01; tick(); irq_in = '0; tick();
        irq_in = 6'h01; tick(); irq_in = '0; tick(); tick();
        rd_chk(3'd0, 32'h1, "edge_merge");
        wr(3'd0, 32'h01);
        rd_chk(3'd0, 32'h0, "edge_merge_clr");
        wr(3'd2, 32'h0);
`else
        wr(3'd2, 32'h01);
        rd_chk(3'd2, 32'h0, "trig_absent");
`endif

        wr(3'd1, 32'h0);
        wr(3'd5, 32'h20);
        chk("sw_hw_masked", 32'(hwint), 32'h0);
        addr = 3'd0; wd = 32'h20; we = 1'b1;
        #1;
        chk("sw_pend_set", rd, 32'h20);
        tick();
        we = 1'b0; wd = '0;
        rd_chk(3'd0, 32'h0, "sw_pend_clr");
        chk("sw_hw_after", 32'(hwint), 32'h0);

        wr(3'd1, 32'h3F);
        wr(3'd5, 32'h3F);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        rd_chk(3'd4, 32'h87, "rst_pre_stat");
        rd_chk(3'd0, 32'h3F, "rst_pre_pend");
        rst = 1'b1; tick(); rst = 1'b0;
        rd_chk(3'd0, 32'h0, "rst_pend");
        rd_chk(3'd4, 32'h7, "rst_stat");
        rd_chk(3'd1, 32'h0, "rst_mask");
        chk("rst_hw", 32'(hwint), 32'h0);

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(299) == 0);
            if ($urandom_range(7) == 0) irq_in = N'($urandom);
            addr = 3'($urandom);
            if ($urandom_range(3) == 0) begin
                we = 1'b1;
                wd = $urandom;
            end else begin
                we = 1'b0;
                wd = '0;
            end
            int_ack = ($urandom_range(5) == 0) && !(we && addr == 3'd6);
            tick();
        end
        rst = 1'b0; we = 1'b0; int_ack = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
